// File: rtl/cprv_ifetch.sv
// cprv_ifetch: instruction fetch front-end with credit-limited imem requests,
// an in-order response FIFO and redirect flush of in-flight responses.
module cprv_ifetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic                   valid_imem_o,
  input  logic                   ready_imem_i,
  output logic [ADDR_WIDTH-1:0]  addr_imem_o,
  input  logic                   valid_imem_i,
  output logic                   ready_imem_o,
  input  logic [INSTR_WIDTH-1:0] rdata_imem_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
  logic [CW:0] used;
  logic req_fire, resp_fire, pop, wr;
  // Credits cover both in-flight and buffered entries, so every response has a slot.
  assign used = {1'b0, out_q} + {1'b0, cnt_q};
  assign valid_imem_o = !rst && used < (CW+1)'(DEPTH);
  assign addr_imem_o = fetch_pc_q;
  assign ready_imem_o = !rst;
  assign valid_o = !rst && cnt_q != '0;
  assign instr_o = instr_mem[rd_q];
  assign pc_o = pc_mem[rd_q];
  assign req_fire = valid_imem_o && ready_imem_i;
  assign resp_fire = valid_imem_i && ready_imem_o;
  assign pop = valid_o && ready_i;
  assign wr = resp_fire && drop_q == '0 && !redirect_i;
  always_comb begin
    out_d = out_q + CW'(req_fire) - CW'(resp_fire);
    fetch_pc_d = redirect_i ? redirect_pc_i : req_fire ? fetch_pc_q + PC_STEP : fetch_pc_q;
    resp_pc_d = redirect_i ? redirect_pc_i : wr ? resp_pc_q + PC_STEP : resp_pc_q;
    drop_d = redirect_i ? out_d : drop_q - CW'(resp_fire && drop_q != '0);
    cnt_d = redirect_i ? '0 : cnt_q + CW'(wr) - CW'(pop);
    wr_d = redirect_i ? '0 : wr_q + PW'(wr);
    rd_d = redirect_i ? '0 : rd_q + PW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      instr_mem[wr_q] <= rdata_imem_i;
      pc_mem[wr_q] <= resp_pc_q;
    end
  end
endmodule

// File: tb/tb_cprv_ifetch.sv
// tb_cprv_ifetch: directed checks of cprv_ifetch against an in-order imem model
// whose instruction word for address a is a ^ 32'hDEAD0000.
module tb_cprv_ifetch;
  localparam logic [31:0] K = 32'hDEAD_0000;
  logic clk = 1'b0;
  logic rst, redirect_i, valid_imem_o, ready_imem_i, valid_imem_i, ready_imem_o, valid_o, ready_i;
  logic [31:0] redirect_pc_i, addr_imem_o, rdata_imem_i, instr_o, pc_o;
  typedef struct packed {logic [31:0] a; int due;} req_t;
  req_t q[$];
  logic [31:0] reqs[$];
  logic [63:0] got[$];
  int cyc = 0;
  int lat = 1;
  int total = 0;
  int passed = 0;
  int failed = 0;

  cprv_ifetch dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_imem_o(valid_imem_o), .ready_imem_i(ready_imem_i), .addr_imem_o(addr_imem_o),
    .valid_imem_i(valid_imem_i), .ready_imem_o(ready_imem_o), .rdata_imem_i(rdata_imem_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  // imem model: responds in order, lat cycles after the accepted request
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid_o && ready_i) got.push_back({pc_o, instr_o});
    if (rst) begin
      q.delete();
      valid_imem_i <= 1'b0;
      rdata_imem_i <= '0;
    end else begin
      if (valid_imem_i && ready_imem_o) void'(q.pop_front());
      if (valid_imem_o && ready_imem_i) begin
        q.push_back('{addr_imem_o, cyc + lat});
        reqs.push_back(addr_imem_o);
      end
      valid_imem_i <= q.size() > 0 && q[0].due <= cyc + 1;
      rdata_imem_i <= q.size() > 0 ? q[0].a ^ K : '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input int i, input logic [31:0] pc);
    logic [63:0] e;
    e = (i < got.size()) ? got[i] : 'x;
    chk({tag, "_pc"}, e[63:32], pc);
    chk({tag, "_instr"}, e[31:0], pc ^ K);
  endtask

  task automatic chk_req(input string tag, input int i, input logic [31:0] a);
    chk(tag, (i < reqs.size()) ? reqs[i] : 'x, a);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    ready_i = rdy;
    step(2);
    reqs.delete();
    got.delete();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ready_i = 1'b1; ready_imem_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    step(3);
    chk("rst_valid_imem", 32'(valid_imem_o), 0);
    chk("rst_ready_imem", 32'(ready_imem_o), 0);
    chk("rst_valid_o", 32'(valid_o), 0);
    reqs.delete(); got.delete();
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(valid_imem_o), 1);
    chk("first_req_addr", addr_imem_o, 32'h0);
    step(1);
    chk("lat_valid_o_n1", 32'(valid_o), 0);
    chk("second_req_addr", addr_imem_o, 32'h4);
    step(1);
    chk("lat_valid_o_n2", 32'(valid_o), 1);
    chk("stream_pc0", pc_o, 32'h0);
    chk("stream_instr0", instr_o, 32'h0 ^ K);
    step(1);
    chk("stream_pc4", pc_o, 32'h4);
    step(1);
    chk("stream_pc8", pc_o, 32'h8);
    chk("stream_instr8", instr_o, 32'h8 ^ K);

    do_reset(1'b0);
    step(10);
    chk("bp_req_count", reqs.size(), 4);
    chk("bp_valid_imem", 32'(valid_imem_o), 0);
    chk("bp_valid_o", 32'(valid_o), 1);
    chk("bp_head_pc", pc_o, 32'h0);
    ready_i = 1'b1;
    step(6);
    chk_pop("bp_pop0", 0, 32'h0);
    chk_pop("bp_pop1", 1, 32'h4);
    chk_pop("bp_pop2", 2, 32'h8);
    chk_pop("bp_pop3", 3, 32'hC);
    chk_pop("bp_pop4", 4, 32'h10);
    chk_req("bp_resume_addr", 4, 32'h10);

    lat = 3;
    do_reset(1'b1);
    step(2);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    step(1);
    redirect_i = 1'b0;
    chk("late_req_count", reqs.size(), 3);
    chk("late_valid_o", 32'(valid_o), 0);
    step(15);
    chk_pop("late_first", 0, 32'h100);
    chk_pop("late_second", 1, 32'h104);

    lat = 1;
    do_reset(1'b1);
    step(2);
    chk("same_req_valid", 32'(valid_imem_o), 1);
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    step(1);
    redirect_i = 1'b0;
    step(8);
    chk_req("same_req_addr", 2, 32'h8);
    chk_pop("same_pop_before", 0, 32'h0);
    chk_pop("same_first", 1, 32'h200);
    chk_pop("same_second", 2, 32'h204);

    do_reset(1'b1);
    step(4);
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    step(1);
    got.delete();
    redirect_pc_i = 32'h80;
    step(1);
    redirect_i = 1'b0;
    step(8);
    chk_pop("b2b_first", 0, 32'h80);
    chk_pop("b2b_second", 1, 32'h84);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    step(1);
    redirect_i = 1'b0;
    got.delete();
    step(8);
    chk_pop("wrap0", 0, 32'hFFFF_FFF8);
    chk_pop("wrap1", 1, 32'hFFFF_FFFC);
    chk_pop("wrap2", 2, 32'h0);

    ready_i = 1'b0;
    step(8);
    chk("full_valid_imem", 32'(valid_imem_o), 0);
    chk("full_valid_o", 32'(valid_o), 1);
    rst = 1'b1;
    step(1);
    chk("midrst_valid_o", 32'(valid_o), 0);
    chk("midrst_valid_imem", 32'(valid_imem_o), 0);
    ready_i = 1'b1;
    step(1);
    reqs.delete(); got.delete();
    rst = 1'b0;
    #1;
    chk("restart_valid", 32'(valid_imem_o), 1);
    chk("restart_addr", addr_imem_o, 32'h0);
    step(6);
    chk_pop("restart_pop0", 0, 32'h0);
    chk_pop("restart_pop1", 1, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
